// File: rtl/sram_100_qsys_arb_pkg.sv
// Shared definitions for the two-master sysid read arbiter: FSM states,
// grant encoding and latency limits.
package sram_100_qsys_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } arb_state_e;

   // Plain constants so the state register stays a bare logic vector.
   localparam logic [1:0] ST_IDLE  = IDLE;
   localparam logic [1:0] ST_ISSUE = ISSUE;
   localparam logic [1:0] ST_WAIT  = WAIT;
   localparam logic [1:0] ST_RESP  = RESP;

   localparam logic GNT_M0 = 1'b0;
   localparam logic GNT_M1 = 1'b1;

   localparam int MAX_SLAVE_LAT = 7;
   localparam int LAT_CNT_W     = 3;

endpackage

// File: rtl/sram_100_qsys_rr_arb2.sv
// Combinational two-way round-robin: on a tie the master that did not win
// last time is granted; a lone requester always wins.
module sram_100_qsys_rr_arb2
   import sram_100_qsys_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic       grant,
   output logic       any_req
);

   always_comb begin
      any_req = |req;
      grant   = GNT_M0;
      if (req == 2'b11) begin
         grant = ~last_grant;
      end else if (req[1]) begin
         grant = GNT_M1;
      end
   end

endmodule

// File: rtl/sram_100_qsys_sysid_arbiter.sv
// Shares one fixed-latency read slave between two Avalon-MM read masters,
// one transaction in flight at a time, round-robin between masters.
// Handshake: a master read is accepted in the single cycle where its
// read is high and waitrequest is low; its data returns as a one-cycle
// readdatavalid strobe SLAVE_LAT+1 cycles later.
module sram_100_qsys_sysid_arbiter
   import sram_100_qsys_arb_pkg::*;
#(
   parameter int ADDR_W    = 1,
   parameter int DATA_W    = 32,
   parameter int SLAVE_LAT = 0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [ADDR_W-1:0] m0_address,
   input  logic              m0_read,
   output logic              m0_waitrequest,
   output logic [DATA_W-1:0] m0_readdata,
   output logic              m0_readdatavalid,
   input  logic [ADDR_W-1:0] m1_address,
   input  logic              m1_read,
   output logic              m1_waitrequest,
   output logic [DATA_W-1:0] m1_readdata,
   output logic              m1_readdatavalid,
   output logic [ADDR_W-1:0] s_address,
   output logic              s_read,
   input  logic [DATA_W-1:0] s_readdata,
   output logic [1:0]        state_dbg
);

   localparam logic [LAT_CNT_W-1:0] LAT_LOAD =
      (SLAVE_LAT > 0) ? LAT_CNT_W'(SLAVE_LAT - 1) : '0;

   logic [1:0]           state;
   logic                 grant;
   logic                 last_grant;
   logic [LAT_CNT_W-1:0] lat_cnt;
   logic                 arb_grant;
   logic                 arb_any;
   logic                 arb_en;
   logic                 capture;

   sram_100_qsys_rr_arb2 u_rr (
      .req        ({m1_read, m0_read}),
      .last_grant (last_grant),
      .grant      (arb_grant),
      .any_req    (arb_any)
   );

   // RESP arbitrates like IDLE so back-to-back reads lose no cycle.
   assign arb_en  = (state == ST_IDLE) || (state == ST_RESP);
   assign capture = ((state == ST_ISSUE) && (SLAVE_LAT == 0)) ||
                    ((state == ST_WAIT) && (lat_cnt == '0));

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= ST_IDLE;
         grant       <= GNT_M0;
         last_grant  <= GNT_M1;
         lat_cnt     <= '0;
         s_address   <= '0;
         m0_readdata <= '0;
         m1_readdata <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_RESP: begin
               if (arb_en && arb_any) begin
                  grant     <= arb_grant;
                  s_address <= (arb_grant == GNT_M1) ? m1_address : m0_address;
                  state     <= ST_ISSUE;
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_ISSUE: begin
               last_grant <= grant;
               if (SLAVE_LAT == 0) begin
                  state <= ST_RESP;
               end else begin
                  lat_cnt <= LAT_LOAD;
                  state   <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (lat_cnt == '0) begin
                  state <= ST_RESP;
               end else begin
                  lat_cnt <= lat_cnt - LAT_CNT_W'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase

         // Each master keeps its last returned word until the next strobe.
         if (capture) begin
            if (grant == GNT_M1) begin
               m1_readdata <= s_readdata;
            end else begin
               m0_readdata <= s_readdata;
            end
         end
      end
   end

   always_comb begin
      s_read           = (state == ST_ISSUE);
      m0_waitrequest   = !((state == ST_ISSUE) && (grant == GNT_M0));
      m1_waitrequest   = !((state == ST_ISSUE) && (grant == GNT_M1));
      m0_readdatavalid = (state == ST_RESP) && (grant == GNT_M0);
      m1_readdatavalid = (state == ST_RESP) && (grant == GNT_M1);
      state_dbg        = state;
   end

endmodule

// File: tb/tb_sram_100_qsys_sysid_arbiter.sv
// Bench for the sysid read arbiter: one instance with a combinational slave,
// one with a three-cycle slave, both scored against a transaction schedule.
module tb_sram_100_qsys_sysid_arbiter;

   localparam int          ADDR_W = 1;
   localparam int          DATA_W = 32;
   localparam logic [31:0] SYSID  = 32'h5FB00F81;
   localparam logic [31:0] JUNK   = 32'hDEADBEEF;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic              rst     [2];
   logic              m_read  [2][2];
   logic [ADDR_W-1:0] m_addr  [2][2];
   logic              m_wait  [2][2];
   logic [DATA_W-1:0] m_rdata [2][2];
   logic              m_rdv   [2][2];
   logic              s_read  [2];
   logic [ADDR_W-1:0] s_addr  [2];
   logic [DATA_W-1:0] s_rdata [2];
   logic [1:0]        st_dbg  [2];

   sram_100_qsys_sysid_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SLAVE_LAT(0)) dut_l0 (
      .clock(clock), .reset(rst[0]),
      .m0_address(m_addr[0][0]), .m0_read(m_read[0][0]), .m0_waitrequest(m_wait[0][0]),
      .m0_readdata(m_rdata[0][0]), .m0_readdatavalid(m_rdv[0][0]),
      .m1_address(m_addr[0][1]), .m1_read(m_read[0][1]), .m1_waitrequest(m_wait[0][1]),
      .m1_readdata(m_rdata[0][1]), .m1_readdatavalid(m_rdv[0][1]),
      .s_address(s_addr[0]), .s_read(s_read[0]), .s_readdata(s_rdata[0]),
      .state_dbg(st_dbg[0])
   );

   sram_100_qsys_sysid_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SLAVE_LAT(3)) dut_l3 (
      .clock(clock), .reset(rst[1]),
      .m0_address(m_addr[1][0]), .m0_read(m_read[1][0]), .m0_waitrequest(m_wait[1][0]),
      .m0_readdata(m_rdata[1][0]), .m0_readdatavalid(m_rdv[1][0]),
      .m1_address(m_addr[1][1]), .m1_read(m_read[1][1]), .m1_waitrequest(m_wait[1][1]),
      .m1_readdata(m_rdata[1][1]), .m1_readdatavalid(m_rdv[1][1]),
      .s_address(s_addr[1]), .s_read(s_read[1]), .s_readdata(s_rdata[1]),
      .state_dbg(st_dbg[1])
   );

   function automatic logic [31:0] rom(input logic [ADDR_W-1:0] a);
      return (a == ADDR_W'(1)) ? SYSID : 32'h0;
   endfunction

   function automatic int lat_of(input int d);
      return (d == 0) ? 0 : 3;
   endfunction

   // Slaves drive junk outside their valid data cycle so mistimed captures show.
   assign s_rdata[0] = s_read[0] ? rom(s_addr[0]) : JUNK;

   logic [2:0]        p_vld = '0;
   logic [ADDR_W-1:0] p_addr [3];
   always @(posedge clock) begin
      p_vld     <= {p_vld[1:0], s_read[1]};
      p_addr[2] <= p_addr[1];
      p_addr[1] <= p_addr[0];
      p_addr[0] <= s_addr[1];
   end
   assign s_rdata[1] = p_vld[2] ? rom(p_addr[2]) : JUNK;

   // ---------------- scoreboard ----------------
   int n_vec = 0;
   int n_bad = 0;
   int cyc   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask

   logic [DATA_W-1:0] exp_q0 [$];
   logic [DATA_W-1:0] exp_q1 [$];

   // Transaction schedule per instance: cycle of accept, cycle of data
   // return, and first cycle at which a new request may be arbitrated.
   int                acc_cyc [2];
   int                resp_cyc[2];
   int                arb_cyc [2];
   logic              gnt     [2];
   logic              last_g  [2];
   logic [ADDR_W-1:0] gnt_addr[2];
   logic              prev_sr [2];

   // Master behaviour and observations.
   logic              pend     [2][2];
   logic              want     [2][2];
   logic [ADDR_W-1:0] want_addr[2][2];
   int                mode     [2];
   int                obs_acc  [2][2];
   int                obs_rdv  [2][2];
   int                n_rdv    [2][2];
   int                n_acc    [2][2];
   int                n_sread  [2];

   task automatic model_reset(input int d);
      acc_cyc[d]  = -1;
      resp_cyc[d] = -1;
      arb_cyc[d]  = cyc + 1;
      last_g[d]   = 1'b1;
      if (d == 0) exp_q0.delete(); else exp_q1.delete();
   endtask

   task automatic check_cycle(input int d);
      logic [DATA_W-1:0] e;
      for (int m = 0; m < 2; m++) begin
         logic ew;
         logic ev;
         ew = !((cyc == acc_cyc[d]) && (gnt[d] == 1'(m)));
         ev = (cyc == resp_cyc[d]) && (gnt[d] == 1'(m));
         check($sformatf("d%0d_m%0d_waitrequest", d, m), 32'(m_wait[d][m]), 32'(ew));
         check($sformatf("d%0d_m%0d_readdatavalid", d, m), 32'(m_rdv[d][m]), 32'(ev));
         if (ev) begin
            if (((d == 0) ? exp_q0.size() : exp_q1.size()) == 0) begin
               check($sformatf("d%0d_exp_q_empty", d), 32'd1, 32'd0);
            end else begin
               e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
               check($sformatf("d%0d_m%0d_readdata", d, m), m_rdata[d][m], e);
            end
         end
         if (m_wait[d][m] === 1'b0) begin obs_acc[d][m] = cyc; n_acc[d][m]++; end
         if (m_rdv[d][m] === 1'b1)  begin obs_rdv[d][m] = cyc; n_rdv[d][m]++; end
      end
      check($sformatf("d%0d_s_read", d), 32'(s_read[d]), 32'(cyc == acc_cyc[d]));
      if (cyc == acc_cyc[d]) check($sformatf("d%0d_s_address", d), 32'(s_addr[d]), 32'(gnt_addr[d]));
      check($sformatf("d%0d_both_wait_low", d), 32'(!m_wait[d][0] && !m_wait[d][1]), 32'd0);
      check($sformatf("d%0d_s_read_b2b", d), 32'(s_read[d] && prev_sr[d]), 32'd0);
      prev_sr[d] = s_read[d];
      if (s_read[d] === 1'b1) n_sread[d]++;
   endtask

   task automatic drive(input int d);
      for (int m = 0; m < 2; m++) begin
         if (rst[d]) begin
            pend[d][m] = 1'b0;
         end else begin
            if (pend[d][m] && !m_wait[d][m]) pend[d][m] = 1'b0;
            if (!pend[d][m]) begin
               m_addr[d][m] = ADDR_W'($urandom_range(0, 1));
               if (want[d][m]) begin
                  pend[d][m]   = 1'b1;
                  m_addr[d][m] = want_addr[d][m];
                  want[d][m]   = 1'b0;
               end else if (mode[d] == 2 || (mode[d] == 1 && $urandom_range(0, 3) == 0)) begin
                  pend[d][m] = 1'b1;
               end
            end
         end
         m_read[d][m] = pend[d][m];
      end
   endtask

   task automatic model_arb(input int d);
      logic w;
      if (rst[d]) begin
         model_reset(d);
      end else if (cyc >= arb_cyc[d]) begin
         if (m_read[d][0] || m_read[d][1]) begin
            w = (m_read[d][0] && m_read[d][1]) ? !last_g[d] : m_read[d][1];
            gnt[d]      = w;
            last_g[d]   = w;
            gnt_addr[d] = m_addr[d][w];
            acc_cyc[d]  = cyc + 1;
            resp_cyc[d] = cyc + 2 + lat_of(d);
            arb_cyc[d]  = resp_cyc[d];
            if (d == 0) exp_q0.push_back(rom(m_addr[d][w]));
            else        exp_q1.push_back(rom(m_addr[d][w]));
         end else begin
            arb_cyc[d] = cyc + 1;
         end
      end
   endtask

   task automatic tick();
      for (int d = 0; d < 2; d++) check_cycle(d);
      for (int d = 0; d < 2; d++) drive(d);
      for (int d = 0; d < 2; d++) model_arb(d);
      @(posedge clock);
      #1;
      cyc++;
   endtask

   function automatic logic all_idle();
      logic r;
      r = 1'b1;
      for (int d = 0; d < 2; d++) begin
         if (cyc <= resp_cyc[d]) r = 1'b0;
         for (int m = 0; m < 2; m++) if (pend[d][m] || want[d][m]) r = 1'b0;
      end
      return r;
   endfunction

   task automatic drain(input int budget);
      int n;
      n = 0;
      while (!all_idle() && n < budget) begin
         tick();
         n++;
      end
      check("drain_timeout", 32'(all_idle()), 32'd1);
      repeat (2) tick();
   endtask

   task automatic reset_one(input int d);
      rst[d] = 1'b1;
      tick();
      rst[d] = 1'b0;
   endtask

   task automatic check_reset_values(input int d);
      for (int m = 0; m < 2; m++) begin
         check($sformatf("d%0d_m%0d_rst_wait", d, m), 32'(m_wait[d][m]), 32'd1);
         check($sformatf("d%0d_m%0d_rst_rdv", d, m), 32'(m_rdv[d][m]), 32'd0);
         check($sformatf("d%0d_m%0d_rst_rdata", d, m), m_rdata[d][m], 32'd0);
      end
      check($sformatf("d%0d_rst_s_read", d), 32'(s_read[d]), 32'd0);
      check($sformatf("d%0d_rst_s_address", d), 32'(s_addr[d]), 32'd0);
   endtask

   initial begin
      int t;
      int a0;
      int s0;
      int r0;
      for (int d = 0; d < 2; d++) begin
         rst[d] = 1'b1;
         mode[d] = 0;
         prev_sr[d] = 1'b0;
         n_sread[d] = 0;
         gnt[d] = 1'b0;
         gnt_addr[d] = '0;
         for (int m = 0; m < 2; m++) begin
            m_read[d][m] = 1'b0; m_addr[d][m] = '0; pend[d][m] = 1'b0; want[d][m] = 1'b0;
            want_addr[d][m] = '0; obs_acc[d][m] = -1; obs_rdv[d][m] = -1;
            n_rdv[d][m] = 0; n_acc[d][m] = 0;
         end
      end
      repeat (2) @(posedge clock);
      #1;
      rst[0] = 1'b0;
      rst[1] = 1'b0;
      cyc = 0;
      for (int d = 0; d < 2; d++) begin
         model_reset(d);
         arb_cyc[d] = 0;
         check_reset_values(d);
      end

      // Lone m0 read of the sysid word on the combinational slave.
      t = cyc;
      want[0][0] = 1'b1; want_addr[0][0] = 1'b1;
      drain(20);
      check("lone_m0_accept_lat", 32'(obs_acc[0][0] - t), 32'd1);
      check("lone_m0_rdv_lat", 32'(obs_rdv[0][0] - t), 32'd2);
      check("lone_m1_no_rdv", 32'(n_rdv[0][1]), 32'd0);

      // Simultaneous requests straight out of reset: m0 first, m1 right after RESP.
      reset_one(0);
      check_reset_values(0);
      r0 = n_rdv[0][0] + n_rdv[0][1];
      t = cyc;
      want[0][0] = 1'b1; want_addr[0][0] = 1'b1;
      want[0][1] = 1'b1; want_addr[0][1] = 1'b0;
      drain(20);
      check("tie_m0_accept", 32'(obs_acc[0][0] - t), 32'd1);
      check("tie_m1_after_m0", 32'(obs_acc[0][1] - obs_acc[0][0]), 32'd2);
      check("tie_two_strobes", 32'(n_rdv[0][0] + n_rdv[0][1] - r0), 32'd2);

      // Both masters hold read continuously: six reads in twelve cycles, alternating.
      a0 = n_acc[0][0];
      s0 = n_acc[0][1];
      mode[0] = 2;
      repeat (12) tick();
      mode[0] = 0;
      check("hold_m0_accepts", 32'(n_acc[0][0] - a0), 32'd3);
      check("hold_m1_accepts", 32'(n_acc[0][1] - s0), 32'd3);
      drain(40);

      // Three-cycle slave: m1 reads address 0.
      s0 = n_sread[1];
      want[1][1] = 1'b1; want_addr[1][1] = 1'b0;
      drain(30);
      check("lat3_rdv_after_accept", 32'(obs_rdv[1][1] - obs_acc[1][1]), 32'd4);
      check("lat3_single_s_read", 32'(n_sread[1] - s0), 32'd1);
      check("lat3_m1_data", m_rdata[1][1], 32'h0);

      // Reset while the three-cycle read is waiting on the slave.
      t = cyc;
      want[1][0] = 1'b1; want_addr[1][0] = 1'b1;
      repeat (3) tick();
      r0 = n_rdv[1][0] + n_rdv[1][1];
      reset_one(1);
      check_reset_values(1);
      repeat (8) tick();
      check("abandoned_no_rdv", 32'(n_rdv[1][0] + n_rdv[1][1] - r0), 32'd0);
      t = cyc;
      want[1][0] = 1'b1; want_addr[1][0] = 1'b1;
      want[1][1] = 1'b1; want_addr[1][1] = 1'b1;
      drain(40);
      check("post_rst_m0_first", 32'(obs_acc[1][0] - t), 32'd1);
      check("post_rst_m1_second", 32'(obs_acc[1][1] - t), 32'd6);

      // Random traffic on both instances.
      mode[0] = 1;
      mode[1] = 1;
      repeat (600) tick();
      mode[0] = 0;
      mode[1] = 0;
      drain(60);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
